// File: rtl/mem_gateway_pkg.sv
// Shared types and default build constants for the memory gateway.
package mem_gateway_pkg;

   localparam int DEF_DATA_W      = 32;
   localparam int DEF_ADDR_W      = 9;
   localparam int DEF_WAIT_CYCLES = 1;
   localparam int CNT_W           = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

endpackage

// File: rtl/mem_gateway_mem_array.sv
// Single-port synchronous RAM with registered read; contents are never reset.
module mem_array
   import mem_gateway_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clock) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_gateway.sv
// MAR/MDR memory gateway: sequences one read or write per request with
// programmable wait states and flags rejected requests.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | accepts MAR/MDR loads and a single read or write request
// ST_ACCESS | wait counter running; memory operation on terminal count
// ST_DONE   | one-cycle completion pulse, then back to idle
module mem_gateway
   import mem_gateway_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic              clock,
   input  logic              clear,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              e_MAR,
   input  logic              e_MDR,
   input  logic              rd_req,
   input  logic              wr_req,
   output logic [ADDR_W-1:0] mar_out,
   output logic [DATA_W-1:0] mdr_out,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

   state_e            state;
   op_e               op;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] mar;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] mdr;
   logic [DATA_W-1:0] acc_data;
   logic              err_q;

   logic              fire;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;

   // The access snapshots MAR/MDR at the request edge, so a same-cycle
   // register load never leaks into the operation in flight.
   assign fire     = (state == ST_ACCESS) && (cnt == '0);
   assign mem_we   = clear && fire && (op == OP_WRITE);
   assign mem_addr = (state == ST_IDLE) ? mar : acc_addr;

   mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clock (clock),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (acc_data),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clock) begin
      if (!clear) begin
         state    <= ST_IDLE;
         op       <= OP_READ;
         cnt      <= '0;
         mar      <= '0;
         mdr      <= '0;
         acc_addr <= '0;
         acc_data <= '0;
         err_q    <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (e_MAR) mar <= bus_in[ADDR_W-1:0];
               if (e_MDR) mdr <= bus_in;
               if (rd_req && wr_req) begin
                  err_q <= 1'b1;
               end else if (rd_req || wr_req) begin
                  op       <= wr_req ? OP_WRITE : OP_READ;
                  acc_addr <= mar;
                  acc_data <= mdr;
                  cnt      <= WAIT_INIT;
                  state    <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (rd_req || wr_req) err_q <= 1'b1;
               if (cnt == '0) begin
                  if (op == OP_READ) mdr <= mem_rdata;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DONE: begin
               if (rd_req || wr_req) err_q <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign mar_out = mar;
   assign mdr_out = mdr;
   assign busy    = (state == ST_ACCESS);
   assign done    = (state == ST_DONE);
   assign err     = err_q;

endmodule

// File: tb/tb_mem_gateway.sv
// Bench for mem_gateway: directed cases plus random traffic against a
// word-level memory model; a second instance covers the zero-wait build.
module tb_mem_gateway;

   localparam int W = 2;

   logic        clock = 1'b0;
   logic        clear;
   logic [31:0] bus_in;
   logic        e_MAR, e_MDR, rd_req, wr_req;
   logic [8:0]  mar_out;
   logic [31:0] mdr_out;
   logic        busy, done, err;

   logic [31:0] bus0;
   logic        e_MAR0, e_MDR0, rd_req0, wr_req0;
   logic [8:0]  mar_out0;
   logic [31:0] mdr_out0;
   logic        busy0, done0, err0;

   int checks = 0;
   int failures = 0;

   logic [8:0]  m_mar;
   logic [31:0] m_mdr;
   logic [31:0] m_mem [int];

   always #5 clock = ~clock;

   mem_gateway #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(W)) u_dut (
      .clock(clock), .clear(clear), .bus_in(bus_in), .e_MAR(e_MAR), .e_MDR(e_MDR),
      .rd_req(rd_req), .wr_req(wr_req), .mar_out(mar_out), .mdr_out(mdr_out),
      .busy(busy), .done(done), .err(err));

   mem_gateway #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(0)) u_dut0 (
      .clock(clock), .clear(clear), .bus_in(bus0), .e_MAR(e_MAR0), .e_MDR(e_MDR0),
      .rd_req(rd_req0), .wr_req(wr_req0), .mar_out(mar_out0), .mdr_out(mdr_out0),
      .busy(busy0), .done(done0), .err(err0));

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input bit em, input bit ed, input logic [31:0] v);
      e_MAR = em; e_MDR = ed; bus_in = v;
      step();
      e_MAR = 1'b0; e_MDR = 1'b0;
      if (em) m_mar = v[8:0];
      if (ed) m_mdr = v;
      check("load_mar", 64'(mar_out), 64'(m_mar));
      check("load_mdr", 64'(mdr_out), 64'(m_mdr));
   endtask

   // Caller may pre-drive e_MAR/e_MDR/bus_in to land on the request edge.
   task automatic access(input bit is_write, input bit poke, input string tag);
      logic [8:0]  a;
      logic [31:0] d;
      int n, nb;
      a = m_mar;
      d = m_mdr;
      if (is_write) wr_req = 1'b1; else rd_req = 1'b1;
      step();
      rd_req = 1'b0; wr_req = 1'b0;
      if (e_MAR) m_mar = bus_in[8:0];
      if (e_MDR) m_mdr = bus_in;
      e_MAR = 1'b0; e_MDR = 1'b0;
      if (is_write) m_mem[int'(a)] = d;
      nb = busy ? 1 : 0;
      n = 0;
      while (!done && n < 20) begin
         step();
         n++;
         if (busy) nb++;
      end
      if (!is_write) m_mdr = m_mem[int'(a)];
      check({tag, "_latency"}, 64'(n), 64'(W + 1));
      check({tag, "_busy_cycles"}, 64'(nb), 64'(W + 1));
      check({tag, "_mdr"}, 64'(mdr_out), 64'(m_mdr));
      check({tag, "_mar"}, 64'(mar_out), 64'(m_mar));
      if (poke) wr_req = 1'b1;
      step();
      wr_req = 1'b0;
      check({tag, "_done_pulse"}, 64'(done), 64'(0));
      check({tag, "_busy_after"}, 64'(busy), 64'(0));
      check({tag, "_err"}, 64'(err), 64'(poke));
   endtask

   initial begin
      int n;
      clear = 1'b0;
      bus_in = '1; e_MAR = 1'b1; e_MDR = 1'b1; rd_req = 1'b1; wr_req = 1'b0;
      bus0 = '0; e_MAR0 = 1'b0; e_MDR0 = 1'b0; rd_req0 = 1'b0; wr_req0 = 1'b0;
      step();
      step();
      check("rst_mar", 64'(mar_out), 64'(0));
      check("rst_mdr", 64'(mdr_out), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      bus_in = '0; e_MAR = 1'b0; e_MDR = 1'b0; rd_req = 1'b0;
      clear = 1'b1;
      m_mar = '0; m_mdr = '0;
      step();

      // write then read back through a cleared MDR
      load(1'b1, 1'b1, 32'hDEADBEEF);
      load(1'b1, 1'b0, 32'h0000_0005);
      load(1'b0, 1'b1, 32'hDEADBEEF);
      access(1'b1, 1'b0, "wr05");
      load(1'b0, 1'b1, 32'h0);
      access(1'b0, 1'b1, "rd05");

      // simultaneous read and write is rejected
      load(1'b0, 1'b1, 32'h1111_1111);
      rd_req = 1'b1; wr_req = 1'b1;
      step();
      rd_req = 1'b0; wr_req = 1'b0;
      check("both_err", 64'(err), 64'(1));
      check("both_busy", 64'(busy), 64'(0));
      step();
      check("both_err_clr", 64'(err), 64'(0));
      check("both_mdr", 64'(mdr_out), 64'(32'h1111_1111));
      access(1'b0, 1'b0, "rd05_again");

      // request and register loads during ACCESS are ignored
      load(1'b0, 1'b1, 32'h2222_2222);
      rd_req = 1'b1;
      step();
      rd_req = 1'b1; e_MDR = 1'b1; e_MAR = 1'b1; bus_in = 32'h1234;
      step();
      rd_req = 1'b0; e_MDR = 1'b0; e_MAR = 1'b0;
      check("acc_err", 64'(err), 64'(1));
      check("acc_mdr_frozen", 64'(mdr_out), 64'(32'h2222_2222));
      check("acc_mar_frozen", 64'(mar_out), 64'(5));
      n = 1;
      while (!done && n < 20) begin step(); n++; end
      check("acc_latency", 64'(n), 64'(W + 1));
      check("acc_mdr", 64'(mdr_out), 64'(32'hDEADBEEF));
      m_mdr = 32'hDEADBEEF;
      step();

      // load and request on the same edge: access uses the old MAR
      e_MAR = 1'b1; bus_in = 32'h0000_0010;
      access(1'b0, 1'b0, "rd_same_edge");

      // reset aborts an in-flight write
      load(1'b0, 1'b1, 32'h0BADF00D);
      access(1'b1, 1'b0, "wr10");
      load(1'b0, 1'b1, 32'hAAAA5555);
      wr_req = 1'b1;
      step();
      wr_req = 1'b0; clear = 1'b0;
      step();
      clear = 1'b1;
      m_mar = '0; m_mdr = '0;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      check("abort_mar", 64'(mar_out), 64'(0));
      check("abort_mdr", 64'(mdr_out), 64'(0));
      n = 0;
      for (int i = 0; i < 5; i++) begin step(); if (done) n++; end
      check("abort_no_done", 64'(n), 64'(0));
      load(1'b1, 1'b0, 32'h0000_0010);
      access(1'b0, 1'b0, "rd10_after_abort");

      // address truncation
      load(1'b1, 1'b0, 32'hFFFFFE03);
      check("mar_trunc", 64'(mar_out), 64'(9'h003));
      load(1'b0, 1'b1, 32'h1357_9BDF);
      access(1'b1, 1'b0, "wr003");
      load(1'b0, 1'b1, 32'h0);
      access(1'b0, 1'b0, "rd003");

      // random traffic
      for (int i = 0; i < 60; i++) begin
         int r;
         r = $urandom_range(0, 3);
         case (r)
            0: load(1'b1, 1'b0, $urandom);
            1: load(1'b0, 1'b1, $urandom);
            2: load(1'b1, 1'b1, $urandom);
            default: begin
               if (!m_mem.exists(int'(m_mar)) || ($urandom_range(0, 1) == 1))
                  access(1'b1, 1'($urandom_range(0, 1)), "rnd_wr");
               else
                  access(1'b0, 1'($urandom_range(0, 1)), "rnd_rd");
            end
         endcase
      end

      // zero-wait build
      e_MAR0 = 1'b1; e_MDR0 = 1'b1; bus0 = 32'hCAFE_F022;
      step();
      e_MAR0 = 1'b0; e_MDR0 = 1'b0;
      wr_req0 = 1'b1;
      step();
      wr_req0 = 1'b0;
      n = 0;
      while (!done0 && n < 20) begin step(); n++; end
      check("w0_wr_latency", 64'(n), 64'(1));
      step();
      e_MDR0 = 1'b1; bus0 = 32'h0;
      step();
      e_MDR0 = 1'b0;
      rd_req0 = 1'b1;
      step();
      rd_req0 = 1'b0;
      check("w0_busy", 64'(busy0), 64'(1));
      check("w0_mdr_pending", 64'(mdr_out0), 64'(0));
      step();
      check("w0_done", 64'(done0), 64'(1));
      check("w0_busy_once", 64'(busy0), 64'(0));
      check("w0_mdr", 64'(mdr_out0), 64'(32'hCAFE_F022));
      step();
      check("w0_done_clr", 64'(done0), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_gateway.md
MEM_GATEWAY -- requirements
Module: mem_gateway

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits.
REQ-002 Parameter ADDR_W, default 9, address width; memory depth SHALL be 2**ADDR_W words.
REQ-003 Parameter WAIT_CYCLES, default 1, range 0..15, extra memory wait states per access.
REQ-004 clock  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 clear  input  1  reset, synchronous, active-low.
REQ-006 bus_in  input  DATA_W  datapath bus value.
REQ-007 e_MAR  input  1  load MAR from bus_in[ADDR_W-1:0].
REQ-008 e_MDR  input  1  load MDR from bus_in.
REQ-009 rd_req  input  1  start memory read at MAR into MDR.
REQ-010 wr_req  input  1  start memory write of MDR to MAR.
REQ-011 mar_out  output  ADDR_W  current MAR.
REQ-012 mdr_out  output  DATA_W  current MDR, drives bus MDR source.
REQ-013 busy  output  1  high while an access is in progress.
REQ-014 done  output  1  one-cycle pulse on access completion.
REQ-015 err  output  1  one-cycle pulse on rejected request.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-017 IDLE: exactly one of rd_req/wr_req high -> latch operation, load wait counter with WAIT_CYCLES, go ACCESS.
REQ-018 IDLE: rd_req and wr_req both high -> no access, err=1 next cycle, stay IDLE.
REQ-019 ACCESS: counter decrements each cycle; at counter==0 the memory operation SHALL occur on that edge and FSM goes DONE.
REQ-020 Read SHALL write mem[MAR] into MDR; write SHALL write MDR into mem[MAR]; each exactly once per access.
REQ-021 Latency: request sampled at edge t0 -> memory operation at edge t0+WAIT_CYCLES+1 -> done high for the cycle following that edge, then IDLE.
REQ-022 busy SHALL be 1 in ACCESS only; done SHALL be 1 in DONE only.
REQ-023 e_MAR/e_MDR SHALL take effect only in IDLE; in ACCESS/DONE they are ignored and MAR/MDR frozen except REQ-020.
REQ-024 e_MAR and e_MDR both high in IDLE SHALL load both registers on the same edge.
REQ-025 e_MAR/e_MDR and a request in the same IDLE cycle: registers load, access uses the pre-edge MAR/MDR values.
REQ-026 rd_req or wr_req while in ACCESS or DONE SHALL be ignored and SHALL pulse err one cycle later.
REQ-027 Requests need not be held; a single-cycle pulse in IDLE suffices.
REQ-028 Back-to-back: a request in DONE is rejected (REQ-026); earliest next start is the first IDLE cycle.
REQ-029 Addresses wrap naturally within ADDR_W bits; no out-of-range condition exists.

Reset
REQ-030 clear=0 at an edge SHALL set FSM=IDLE, counter=0, MAR=0, MDR=0, busy=0, done=0, err=0.
REQ-031 Reset mid-ACCESS SHALL abort: pending write not performed, pending read not loaded.
REQ-032 Memory contents SHALL NOT be altered by reset.
REQ-033 clear=0 SHALL override every other input in the same cycle.

Structure
REQ-034 Package mem_gateway_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-035 Storage SHALL be one sub-module mem_array (single-port synchronous RAM, DATA_W x 2**ADDR_W, write enable, no reset).
REQ-036 Wait counter width SHALL be 4 bits regardless of WAIT_CYCLES.

Verification (DATA_W=32, ADDR_W=9, WAIT_CYCLES=2 unless noted)
REQ-037 Write then read: MAR=0x05, MDR=0xDEADBEEF, wr_req pulse; MDR<=0, rd_req -> done 3 cycles after each request, mdr_out=0xDEADBEEF.
REQ-038 WAIT_CYCLES=0 build: rd_req at t0 -> MDR updated at t0+1, done high cycle t0+1..t0+2, busy high exactly one cycle.
REQ-039 rd_req and wr_req together in IDLE -> err one pulse, busy stays 0, memory and MDR unchanged.
REQ-040 rd_req during ACCESS plus e_MDR=1 with bus_in=0x1234 -> err pulse, MDR unaffected by bus, original access completes normally.
REQ-041 wr_req to 0x10 with 0xAAAA5555, clear=0 one cycle after -> outputs zeroed; later read of 0x10 returns prior content, not 0xAAAA5555.
REQ-042 MAR loaded with bus_in=0xFFFFFE03 -> mar_out=0x003; write/read there round-trips correctly.
